// File: rtl/eth_pkg.sv
// eth_pkg: shared state encoding, CRC-32 constants and RMII dibit codes for the Ethernet blocks
package eth_pkg;
  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_PREAMBLE = 3'd1,
    S_DATA     = 3'd2,
    S_DONE     = 3'd3,
    S_WAIT_ACK = 3'd4
  } state_e;
  localparam logic [31:0] CRC32_POLY_REFL = 32'hEDB88320;
  localparam logic [31:0] CRC32_INIT      = 32'hFFFFFFFF;
  localparam logic [31:0] CRC32_RESIDUE   = 32'hDEBB20E3;
  localparam logic [1:0]  DIBIT_PRE       = 2'b01;
  localparam logic [1:0]  DIBIT_SFD       = 2'b11;
  localparam int ERR_ALIGN = 0;
  localparam int ERR_RUNT  = 1;
  localparam int ERR_LONG  = 2;
endpackage

// File: rtl/eth_crc32_d8.sv
// eth_crc32_d8: combinational reflected CRC-32 update for one byte, shared by RX and TX
module eth_crc32_d8
  import eth_pkg::*;
(
  input  logic [31:0] crc_i,
  input  logic [7:0]  data_i,
  output logic [31:0] crc_o
);
  logic [31:0] c;
  always_comb begin
    c = crc_i ^ {24'd0, data_i};
    for (int i = 0; i < 8; i++) c = c[0] ? (c >> 1) ^ CRC32_POLY_REFL : c >> 1;
    crc_o = c;
  end
endmodule

// File: rtl/eth_rx.sv
// eth_rx: RMII receive engine writing frames to RAM with CRC-32/length status and done/ack handshake
// ETH_RX_DEBUG_EN adds d_crc32/d_state observation ports.
module eth_rx
  import eth_pkg::*;
#(
  parameter logic [10:0] PAKET_MAX_SIZE = 11'd1518,
  parameter logic [10:0] PAKET_MIN_SIZE = 11'd64
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic [1:0]  i_eth_data,
  input  logic        i_eth_crs_dv,
  output logic [10:0] o_ram_adr,
  output logic [7:0]  o_ram_data,
  output logic        o_ram_we,
  output logic        o_rx_done,
  output logic [10:0] o_rx_len,
  output logic        o_crc_ok,
  output logic [2:0]  o_rx_err,
  input  logic        i_rx_ack,
  output logic        o_rx_ready,
  output logic [15:0] o_drop_cnt
`ifdef ETH_RX_DEBUG_EN
  ,
  output logic [31:0] d_crc32,
  output logic [2:0]  d_state
`endif
);
  state_e      state_q, state_d;
  logic [5:0]  sh_q;
  logic [1:0]  dib_q;
  logic        we_q, we_d, ack_q, drop_act_q;
  logic [7:0]  data_q;
  logic [10:0] cnt_q, cnt_eff, len_q;
  logic [31:0] crc_q, crc_nxt, crc_fin;
  logic        crc_ok_q, is_long;
  logic [2:0]  err_q;
  logic [15:0] drop_q;

  eth_crc32_d8 u_crc (.crc_i(crc_q), .data_i(data_q), .crc_o(crc_nxt));

  // a byte still waiting in the write stage counts toward length and CRC
  assign cnt_eff = cnt_q + 11'(we_q);
  assign crc_fin = we_q ? crc_nxt : crc_q;
  assign is_long = cnt_eff == PAKET_MAX_SIZE;
  assign we_d    = state_q == S_DATA && i_eth_crs_dv && dib_q == 2'd3 && cnt_eff < PAKET_MAX_SIZE;

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:     state_d = i_eth_crs_dv && i_eth_data == DIBIT_PRE ? S_PREAMBLE : S_IDLE;
      S_PREAMBLE: state_d = !i_eth_crs_dv ? S_IDLE :
                            i_eth_data == DIBIT_SFD ? S_DATA :
                            i_eth_data == DIBIT_PRE ? S_PREAMBLE : S_IDLE;
      S_DATA:     state_d = i_eth_crs_dv ? S_DATA : S_DONE;
      S_DONE:     state_d = S_WAIT_ACK;
      S_WAIT_ACK: state_d = i_rx_ack || ack_q ? S_IDLE : S_WAIT_ACK;
      default:    state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q    <= S_IDLE;
      sh_q       <= '0;
      dib_q      <= '0;
      we_q       <= 1'b0;
      data_q     <= '0;
      cnt_q      <= '0;
      crc_q      <= CRC32_INIT;
      len_q      <= '0;
      crc_ok_q   <= 1'b0;
      err_q      <= '0;
      ack_q      <= 1'b0;
      drop_act_q <= 1'b0;
      drop_q     <= '0;
    end else begin
      state_q <= state_d;
      we_q    <= we_d;
      ack_q   <= state_q == S_DONE && i_rx_ack;
      if (we_q) begin
        crc_q <= crc_nxt;
        cnt_q <= cnt_q + 11'd1;
      end
      if (state_q == S_PREAMBLE && state_d == S_DATA) begin
        cnt_q <= '0;
        crc_q <= CRC32_INIT;
        dib_q <= '0;
      end
      if (state_q == S_DATA && i_eth_crs_dv) begin
        dib_q <= dib_q + 2'd1;
        sh_q  <= {i_eth_data, sh_q[5:2]};
        if (dib_q == 2'd3) data_q <= {i_eth_data, sh_q};
      end
      if (state_q == S_DATA && !i_eth_crs_dv) begin
        len_q           <= cnt_eff;
        crc_ok_q        <= crc_fin == CRC32_RESIDUE && !is_long;
        err_q[ERR_LONG]  <= is_long;
        err_q[ERR_RUNT]  <= cnt_eff < PAKET_MIN_SIZE;
        err_q[ERR_ALIGN] <= dib_q != 2'd0;
      end
      // frames arriving before the ack are counted once, on their carrier fall
      if (state_q == S_WAIT_ACK && i_eth_crs_dv && i_eth_data == DIBIT_PRE && !drop_act_q)
        drop_act_q <= 1'b1;
      else if (drop_act_q && !i_eth_crs_dv) begin
        drop_act_q <= 1'b0;
        drop_q     <= drop_q == 16'hFFFF ? drop_q : drop_q + 16'd1;
      end
    end
  end

  assign o_ram_adr  = cnt_q;
  assign o_ram_data = data_q;
  assign o_ram_we   = we_q;
  assign o_rx_done  = state_q == S_DONE;
  assign o_rx_len   = len_q;
  assign o_crc_ok   = crc_ok_q;
  assign o_rx_err   = err_q;
  assign o_rx_ready = state_q == S_IDLE;
  assign o_drop_cnt = drop_q;
`ifdef ETH_RX_DEBUG_EN
  assign d_crc32 = crc_q;
  assign d_state = state_q;
`endif
endmodule

// File: tb/tb_eth_rx.sv
// tb_eth_rx: randomized and directed checks of eth_rx against a frame-level reference model
module tb_eth_rx;
  logic clk = 1'b0, rst = 1'b1, crs = 1'b0, ack = 1'b0;
  logic [1:0]  dat = 2'b00;
  logic [10:0] ram_adr, rx_len;
  logic [7:0]  ram_data;
  logic        ram_we, rx_done, crc_ok, rx_ready;
  logic [2:0]  rx_err;
  logic [15:0] drop_cnt;
`ifdef ETH_RX_DEBUG_EN
  logic [31:0] d_crc32;
  logic [2:0]  d_state;
`endif
  int n_vec = 0, n_err = 0, cyc = 0, done_n = 0, done_cyc = 0, fall_cyc = 0;
  logic [7:0]  fr[$];
  logic [18:0] wq[$];

  eth_rx dut (
    .i_clk(clk), .i_rst(rst), .i_eth_data(dat), .i_eth_crs_dv(crs),
    .o_ram_adr(ram_adr), .o_ram_data(ram_data), .o_ram_we(ram_we),
    .o_rx_done(rx_done), .o_rx_len(rx_len), .o_crc_ok(crc_ok), .o_rx_err(rx_err),
    .i_rx_ack(ack), .o_rx_ready(rx_ready), .o_drop_cnt(drop_cnt)
`ifdef ETH_RX_DEBUG_EN
    , .d_crc32(d_crc32), .d_state(d_state)
`endif
  );

  always #10 clk = ~clk;
  always @(posedge clk) cyc++;
  always @(negedge clk) begin
    if (ram_we) wq.push_back({ram_adr, ram_data});
    if (rx_done) begin
      done_n++;
      done_cyc = cyc;
    end
  end

  initial begin
    #3ms;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] crc_of(input int n);
    logic [31:0] c = 32'hFFFFFFFF;
    for (int i = 0; i < n; i++) begin
      c ^= {24'd0, fr[i]};
      for (int b = 0; b < 8; b++) c = c[0] ? (c >> 1) ^ 32'hEDB88320 : c >> 1;
    end
    return c;
  endfunction

  function automatic void mk_frame(input int n, input bit seq);
    logic [31:0] c;
    fr.delete();
    for (int i = 0; i < n; i++) fr.push_back(seq ? 8'(i) : 8'($urandom));
    c = ~crc_of(n);
    for (int k = 0; k < 4; k++) fr.push_back(c[8*k +: 8]);
  endfunction

  function automatic bit fcs_good();
    int n = fr.size();
    if (n < 4) return 1'b0;
    return {fr[n-1], fr[n-2], fr[n-3], fr[n-4]} == ~crc_of(n - 4);
  endfunction

  task automatic put(input logic v, input logic [1:0] d);
    @(negedge clk);
    crs = v;
    dat = d;
  endtask

  task automatic drive_frame(input int extra, input int rst_at);
    logic [7:0] b;
    repeat (31) put(1'b1, 2'b01);
    put(1'b1, 2'b11);
    for (int i = 0; i < fr.size(); i++) begin
      if (i == rst_at) begin
        @(negedge clk);
        rst = 1'b1;
        crs = 1'b0;
        dat = 2'b00;
        @(negedge clk);
        rst = 1'b0;
        return;
      end
      b = fr[i];
      for (int j = 0; j < 4; j++) put(1'b1, b[2*j +: 2]);
    end
    repeat (extra) put(1'b1, 2'($urandom));
    put(1'b0, 2'b00);
    fall_cyc = cyc;
  endtask

  task automatic wait_done(input bit ack_now);
    bit seen = 1'b0;
    for (int k = 0; k < 20 && !seen; k++) begin
      @(negedge clk);
      if (rx_done) begin
        seen = 1'b1;
        if (ack_now) ack = 1'b1;
      end
    end
    chk("done_seen", 32'(seen), 32'd1);
    #1;
  endtask

  task automatic check_frame(input int extra);
    int n = fr.size();
    int nw = n > 1518 ? 1518 : n;
    int bad = 0;
    bit lng = n >= 1518;
    chk("done_cnt", done_n, 1);
    chk("done_lat", done_cyc - fall_cyc, 1);
    chk("wr_cnt", wq.size(), nw);
    for (int i = 0; i < wq.size() && i < nw; i++)
      if (wq[i] !== {11'(i), fr[i]}) bad++;
    chk("wr_data", bad, 0);
    chk("rx_len", 32'(rx_len), nw);
    chk("crc_ok", 32'(crc_ok), 32'(!lng && fcs_good()));
    chk("rx_err", 32'(rx_err), 32'({lng, nw < 64, extra != 0}));
  endtask

  task automatic run_frame(input int extra, input bit ack_now);
    wq.delete();
    done_n = 0;
    drive_frame(extra, -1);
    wait_done(ack_now);
    check_frame(extra);
    if (ack_now) begin
      @(negedge clk);
      ack = 1'b0;
    end else begin
      @(negedge clk);
      ack = 1'b1;
      @(negedge clk);
      ack = 1'b0;
    end
    @(negedge clk);
    chk("ready", 32'(rx_ready), 32'd1);
  endtask

  initial begin
    int n, ex;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_ready", 32'(rx_ready), 32'd1);
    chk("rst_done", 32'(rx_done), 32'd0);
    chk("rst_we", 32'(ram_we), 32'd0);
    chk("rst_adr", 32'(ram_adr), 32'd0);
    chk("rst_len", 32'(rx_len), 32'd0);
    chk("rst_ok", 32'(crc_ok), 32'd0);
    chk("rst_err", 32'(rx_err), 32'd0);
    chk("rst_drop", 32'(drop_cnt), 32'd0);

    mk_frame(60, 1'b1);
    run_frame(0, 1'b0);
    mk_frame(60, 1'b1);
    fr[10] ^= 8'h01;
    run_frame(0, 1'b1);

    wq.delete();
    done_n = 0;
    repeat (3) put(1'b1, 2'b01);
    put(1'b0, 2'b00);
    put(1'b1, 2'b01);
    put(1'b1, 2'b01);
    put(1'b1, 2'b10);
    put(1'b0, 2'b00);
    repeat (10) @(negedge clk);
    chk("abort_wr", wq.size(), 0);
    chk("abort_done", done_n, 0);
    chk("abort_ready", 32'(rx_ready), 32'd1);

    mk_frame(60, 1'b1);
    run_frame(2, 1'b0);
    mk_frame(1596, 1'b0);
    run_frame(0, 1'b1);

    mk_frame(60, 1'b0);
    wq.delete();
    done_n = 0;
    drive_frame(0, -1);
    wait_done(1'b0);
    check_frame(0);
    mk_frame(70, 1'b0);
    wq.delete();
    done_n = 0;
    drive_frame(0, -1);
    repeat (5) @(negedge clk);
    chk("drop_wr", wq.size(), 0);
    chk("drop_done", done_n, 0);
    chk("drop_cnt", 32'(drop_cnt), 32'd1);
    chk("drop_len", 32'(rx_len), 32'd64);
    chk("drop_err", 32'(rx_err), 32'd0);
    chk("drop_ok", 32'(crc_ok), 32'd1);
    chk("drop_ready", 32'(rx_ready), 32'd0);
    ack = 1'b1;
    @(negedge clk);
    ack = 1'b0;
    mk_frame(90, 1'b0);
    run_frame(0, 1'b0);
    chk("drop_keep", 32'(drop_cnt), 32'd1);

    mk_frame(60, 1'b1);
    done_n = 0;
    drive_frame(0, 20);
    repeat (5) @(negedge clk);
    chk("mrst_done", done_n, 0);
    chk("mrst_ready", 32'(rx_ready), 32'd1);
    chk("mrst_len", 32'(rx_len), 32'd0);
    chk("mrst_ok", 32'(crc_ok), 32'd0);
    chk("mrst_err", 32'(rx_err), 32'd0);
    chk("mrst_drop", 32'(drop_cnt), 32'd0);
    chk("mrst_we", 32'(ram_we), 32'd0);

    for (int t = 0; t < 20; t++) begin
      n = $urandom_range(4, 150);
      mk_frame(n, 1'b0);
      if ($urandom_range(0, 2) == 0) fr[$urandom_range(0, n + 3)] ^= 8'(1 << $urandom_range(0, 7));
      ex = $urandom_range(0, 3) == 0 ? $urandom_range(1, 3) : 0;
      run_frame(ex, 1'($urandom_range(0, 1)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
